// File: rtl/cas_tape_player.sv
// rtl/cas_tape_player.sv - CAS image capture buffer and pulse-encoded tape playback
module cas_tape_player #(
    parameter int         ADDR_W       = 16,
    parameter logic [7:0] CAS_INDEX    = 8'd1,
    parameter int         CELL_CYCLES  = 2400,
    parameter int         PULSE_CYCLES = 200
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    input  logic              tape_play,
    output logic              tape_out,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] position
);
    localparam int CW = $clog2(CELL_CYCLES);
    localparam logic [CW-1:0] C_LAST    = CW'(CELL_CYCLES - 1);
    localparam logic [CW-1:0] C_PULSE   = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] C_MID     = CW'(CELL_CYCLES / 2);
    localparam logic [CW-1:0] C_MID_END = CW'(CELL_CYCLES / 2 + PULSE_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRIME, S_BIT, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_mem [0:2**ADDR_W-1];
    logic [7:0]        r_rdata;
    logic              r_dl_q;
    logic [ADDR_W:0]   r_length;
    logic [ADDR_W-1:0] r_position;
    logic [CW-1:0]     r_cell_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shreg;
    logic [7:0]        r_nxt;

    logic              w_accept, w_dl_rise, w_cell_end, w_last_byte, w_byte_end;
    logic [ADDR_W:0]   w_wlen;
    logic [ADDR_W-1:0] w_pos_inc, w_raddr;

    assign w_accept    = ioctl_download & ioctl_wr & (ioctl_index == CAS_INDEX)
                         & (ioctl_addr < 25'(2**ADDR_W));
    assign w_dl_rise   = ioctl_download & ~r_dl_q & (ioctl_index == CAS_INDEX);
    assign w_wlen      = (ADDR_W+1)'(ioctl_addr[ADDR_W-1:0]) + (ADDR_W+1)'(1);
    assign w_pos_inc   = r_position + ADDR_W'(1);
    assign w_cell_end  = (r_cell_cnt == C_LAST);
    assign w_last_byte = (({1'b0, r_position} + (ADDR_W+1)'(1)) == r_length);
    assign w_byte_end  = (r_state == S_BIT) & tape_play & w_cell_end & (r_bit_idx == 3'd0);
    // BIT always reads the following byte, so nxt is ready long before the byte ends
    assign w_raddr     = (r_state == S_BIT) ? w_pos_inc : r_position;
    assign length      = r_length;
    assign position    = r_position;

    always_ff @(posedge clk_sys) begin
        if (w_accept) begin
            r_mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
        end
        r_rdata <= r_mem[w_accept ? ioctl_addr[ADDR_W-1:0] : w_raddr];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_dl_rise) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (tape_play && !ioctl_download && r_length != '0) w_next = S_FETCH;
                S_FETCH: if (tape_play) w_next = S_PRIME;
                S_PRIME: if (tape_play) w_next = S_BIT;
                S_BIT:   if (w_byte_end && w_last_byte) w_next = S_DONE;
                S_DONE:  if (!tape_play) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        playing  = (r_state == S_FETCH) || (r_state == S_PRIME) || (r_state == S_BIT);
        done     = (r_state == S_DONE);
        tape_out = 1'b0;
        if (r_state == S_BIT && tape_play) begin
            tape_out = (r_cell_cnt < C_PULSE)
                     || (r_shreg[7] && r_cell_cnt >= C_MID && r_cell_cnt < C_MID_END);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl_q     <= 1'b0;
            r_length   <= '0;
            r_position <= '0;
            r_cell_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shreg    <= 8'd0;
            r_nxt      <= 8'd0;
        end else begin
            r_dl_q <= ioctl_download;
            if (w_dl_rise) begin
                r_length <= w_accept ? w_wlen : '0;
            end else if (w_accept && w_wlen > r_length) begin
                r_length <= w_wlen;
            end

            if (w_dl_rise) begin
                r_position <= '0;
            end else if (r_state == S_DONE && !tape_play) begin
                r_position <= '0;
            end else if (w_byte_end && !w_last_byte) begin
                r_position <= w_pos_inc;
            end

            if (!w_dl_rise && tape_play) begin
                if (r_state == S_PRIME) begin
                    r_shreg    <= r_rdata;
                    r_bit_idx  <= 3'd7;
                    r_cell_cnt <= '0;
                end else if (r_state == S_BIT) begin
                    if (r_bit_idx == 3'd0) begin
                        r_nxt <= r_rdata;
                    end
                    if (w_cell_end) begin
                        r_cell_cnt <= '0;
                        if (r_bit_idx != 3'd0) begin
                            r_shreg   <= {r_shreg[6:0], 1'b0};
                            r_bit_idx <= r_bit_idx - 3'd1;
                        end else if (!w_last_byte) begin
                            r_shreg   <= r_nxt;
                            r_bit_idx <= 3'd7;
                        end
                    end else begin
                        r_cell_cnt <= r_cell_cnt + CW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cas_tape_player.sv
// tb/tb_cas_tape_player.sv - capture table plus scoreboarded waveform checks for cas_tape_player
module tb_cas_tape_player;
    localparam int ADDR_W = 4;
    localparam int CELL   = 16;
    localparam int PULSE  = 2;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download, ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout, ioctl_index;
    logic              tape_play;
    logic              tape_out, playing, done;
    logic [ADDR_W:0]   length;
    logic [ADDR_W-1:0] position;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic t; logic p; logic [ADDR_W-1:0] pos; } exp_t;
    exp_t exp_q[$];

    typedef struct { logic nd; logic [7:0] idx; logic [24:0] addr; logic [7:0] data; int exp_len; } cap_t;
    cap_t cv [7];

    cas_tape_player #(.ADDR_W(ADDR_W), .CAS_INDEX(8'd1), .CELL_CYCLES(CELL), .PULSE_CYCLES(PULSE)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .tape_play(tape_play), .tape_out(tape_out), .playing(playing), .done(done),
        .length(length), .position(position)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys); ioctl_download = 1'b0;
        @(negedge clk_sys); ioctl_index = idx; ioctl_download = 1'b1;
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        @(negedge clk_sys); ioctl_wr = 1'b0;
    endtask

    task automatic end_dl();
        @(negedge clk_sys); ioctl_download = 1'b0;
    endtask

    task automatic play_check(input logic [7:0] img [4], input int n, input int p_at, input int p_len);
        exp_t e;
        exp_t pe;
        int   i;
        e = '{t: 1'b0, p: 1'b1, pos: '0};
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int b = 0; b < n; b++)
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < CELL; c++) begin
                    e.t   = (c < PULSE) || (img[b][7-k] && c >= CELL/2 && c < CELL/2 + PULSE);
                    e.p   = 1'b1;
                    e.pos = ADDR_W'(b);
                    exp_q.push_back(e);
                end
        if (p_at >= 0) begin
            pe = '{t: 1'b0, p: 1'b1, pos: exp_q[p_at].pos};
            for (int j = 0; j < p_len; j++) exp_q.insert(p_at, pe);
        end
        tape_play = 1'b1;
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk_sys);
            if (i == p_at) tape_play = 1'b0;
            if (p_at >= 0 && i == p_at + p_len) tape_play = 1'b1;
            #1;
            e = exp_q.pop_front();
            chk("tape_out", int'(tape_out), int'(e.t));
            chk("playing", int'(playing), int'(e.p));
            chk("position", int'(position), int'(e.pos));
            i++;
        end
        @(negedge clk_sys); #1;
        chk("done_after_last", int'(done), 1);
        chk("playing_after_last", int'(playing), 0);
        chk("tape_out_in_done", int'(tape_out), 0);
        chk("position_in_done", int'(position), n - 1);
    endtask

    initial begin
        logic [7:0] img [4];
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; tape_play = 1'b0;
        #1;
        chk("rst_tape_out", int'(tape_out), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_length", int'(length), 0);
        chk("rst_position", int'(position), 0);
        @(negedge clk_sys); @(negedge clk_sys);
        reset = 1'b0;

        // empty buffer: play must not start
        tape_play = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys); #1;
            chk("empty_playing", int'(playing), 0);
            chk("empty_tape_out", int'(tape_out), 0);
        end
        tape_play = 1'b0;

        cv[0] = '{nd: 1'b1, idx: 8'd2, addr: 25'd0,        data: 8'h11, exp_len: 0};
        cv[1] = '{nd: 1'b1, idx: 8'd1, addr: 25'd3,        data: 8'h22, exp_len: 4};
        cv[2] = '{nd: 1'b0, idx: 8'd1, addr: 25'd1,        data: 8'h33, exp_len: 4};
        cv[3] = '{nd: 1'b0, idx: 8'd1, addr: 25'd16,       data: 8'h44, exp_len: 4};
        cv[4] = '{nd: 1'b0, idx: 8'd1, addr: 25'd15,       data: 8'h55, exp_len: 16};
        cv[5] = '{nd: 1'b0, idx: 8'd1, addr: 25'h100000,   data: 8'h66, exp_len: 16};
        cv[6] = '{nd: 1'b1, idx: 8'd1, addr: 25'd0,        data: 8'hA5, exp_len: 1};
        for (int i = 0; i < 7; i++) begin
            if (cv[i].nd) start_dl(cv[i].idx);
            wr(cv[i].addr, cv[i].data);
            #1;
            chk($sformatf("length_vec%0d", i), int'(length), cv[i].exp_len);
        end
        end_dl();

        img = '{8'hA5, 8'h00, 8'h00, 8'h00};
        play_check(img, 1, -1, 0);
        tape_play = 1'b0;
        @(negedge clk_sys); #1;
        chk("rewind_done", int'(done), 0);
        chk("rewind_position", int'(position), 0);

        start_dl(8'd1);
        wr(25'd0, 8'hFF);
        wr(25'd1, 8'h00);
        end_dl();
        #1;
        chk("length_two", int'(length), 2);
        img = '{8'hFF, 8'h00, 8'h00, 8'h00};
        play_check(img, 2, -1, 0);
        tape_play = 1'b0;
        @(negedge clk_sys); #1;
        chk("rewind2_position", int'(position), 0);
        chk("rewind2_playing", int'(playing), 0);

        // replay from the start with a 40-cycle pause at bit 3, cell 5
        play_check(img, 2, 2 + 3*CELL + 5, 40);
        tape_play = 1'b0;
        @(negedge clk_sys);

        tape_play = 1'b1;
        repeat (140) @(negedge clk_sys);
        #1;
        chk("midplay_position", int'(position), 1);
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        @(negedge clk_sys); #1;
        chk("redl_playing", int'(playing), 0);
        chk("redl_length", int'(length), 0);
        chk("redl_position", int'(position), 0);
        tape_play = 1'b0;
        wr(25'd0, 8'h3C);
        wr(25'd1, 8'h81);
        wr(25'd2, 8'h7E);
        end_dl();
        #1;
        chk("length_three", int'(length), 3);
        img = '{8'h3C, 8'h81, 8'h7E, 8'h00};
        play_check(img, 3, -1, 0);
        tape_play = 1'b0;
        @(negedge clk_sys);

        tape_play = 1'b1;
        repeat (35) @(negedge clk_sys);
        #1;
        chk("pre_reset_tape_out", int'(tape_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_tape_out", int'(tape_out), 0);
        chk("areset_playing", int'(playing), 0);
        chk("areset_done", int'(done), 0);
        chk("areset_length", int'(length), 0);
        chk("areset_position", int'(position), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        tape_play = 1'b0;
        @(negedge clk_sys);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
